// File: rtl/lane_spawner.sv
// ============================================================================
// Module   : lane_spawner
// Purpose  : Per-lane traffic controller feeding a bank of car instances.
//            Decides when each car slot is spawned and retired, picks a
//            random car type and inter-car gap from an 8-bit Galois LFSR,
//            and drives the lane-constant spawn position/direction/speed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_spawner #(
   parameter int unsigned  SLOTS     = 4,
   parameter logic [9:0]   LANE_Y    = 10'd200,
   parameter logic         FACE_LEFT = 1'b0,
   parameter logic [2:0]   SPEED     = 3'd2,
   parameter logic [10:0]  LIFETIME  = 11'd690,
   parameter logic [7:0]   MIN_GAP   = 8'd20,
   parameter logic [5:0]   GAP_MASK  = 6'h1F,
   parameter logic [7:0]   SEED      = 8'hA5
) (
   input  logic                 FrameClk,
   input  logic                 ResetN,
   input  logic                 LaneEnable,
   output logic [SLOTS-1:0]     SpawnEnable,
   output logic [2*SLOTS-1:0]   Type,
   output logic [9:0]           SpawnX,
   output logic [9:0]           SpawnY,
   output logic                 FaceLeft,
   output logic [2:0]           Speed,
   output logic [2:0]           ActiveCount
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_COOL   = 2'd2
   } slot_state_e;

   // Age value on the last enabled frame of a slot's lifetime.
   localparam logic [10:0] AGE_LAST  = LIFETIME - 11'd1;
   localparam logic [7:0]  LFSR_TAPS = 8'hB8;

   slot_state_e [SLOTS-1:0]        state_q, state_d;
   logic [SLOTS-1:0][10:0]         age_q, age_d;
   logic [2*SLOTS-1:0]             type_q, type_d;
   logic [SLOTS-1:0]               spawn_en_q, spawn_en_d;
   logic [7:0]                     gap_q, gap_d;
   logic [7:0]                     lfsr_q, lfsr_d;
   logic [2:0]                     active_cnt_q, active_cnt_d;
   logic [8:0]                     gap_sum;
   logic [7:0]                     gap_reload;
   logic                           spawn_done;

   // Lane constants are pure parameter decodes.
   assign SpawnX   = FACE_LEFT ? 10'd740 : 10'd51;
   assign SpawnY   = LANE_Y;
   assign FaceLeft = FACE_LEFT;
   assign Speed    = SPEED;

   assign SpawnEnable = spawn_en_q;
   assign Type        = type_q;
   assign ActiveCount = active_cnt_q;

   // Gap reload from the pre-advance LFSR, saturating at 8'hFF.
   always_comb begin
      gap_sum    = {1'b0, MIN_GAP} + {3'b000, lfsr_q[7:2] & GAP_MASK};
      gap_reload = gap_sum[8] ? 8'hFF : gap_sum[7:0];
   end

   // Next-state logic for LFSR, gap counter, slot FSMs, ages and types.
   always_comb begin
      lfsr_d       = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
      gap_d        = gap_q;
      state_d      = state_q;
      age_d        = age_q;
      type_d       = type_q;
      spawn_done   = 1'b0;
      spawn_en_d   = '0;
      active_cnt_d = 3'd0;

      if (!LaneEnable) begin
         // Lane halted: retire everything, no spawning, restart gap.
         gap_d = MIN_GAP;
         for (int k = 0; k < SLOTS; k++) begin
            state_d[k] = (state_q[k] == S_ACTIVE) ? S_COOL : S_IDLE;
            age_d[k]   = 11'd0;
         end
      end else begin
         for (int k = 0; k < SLOTS; k++) begin
            case (state_q[k])
               S_ACTIVE: begin
                  if (age_q[k] == AGE_LAST) begin
                     state_d[k] = S_COOL;
                     age_d[k]   = 11'd0;
                  end else begin
                     age_d[k] = age_q[k] + 11'd1;
                  end
               end
               S_COOL:  state_d[k] = S_IDLE;
               default: state_d[k] = S_IDLE;
            endcase
         end

         if (gap_q != 8'd0) begin
            gap_d = gap_q - 8'd1;
         end else begin
            // A slot is eligible unless it is ACTIVE at this edge: a slot
            // retiring now is still ACTIVE and so cannot respawn, while a
            // COOL slot has already given the car its one low frame.
            for (int k = 0; k < SLOTS; k++) begin
               if (!spawn_done && (state_q[k] != S_ACTIVE)) begin
                  spawn_done       = 1'b1;
                  state_d[k]       = S_ACTIVE;
                  age_d[k]         = 11'd0;
                  type_d[2*k +: 2] = lfsr_q[1:0];
                  gap_d            = gap_reload;
               end
            end
         end
      end

      for (int k = 0; k < SLOTS; k++) begin
         spawn_en_d[k] = (state_d[k] == S_ACTIVE);
         if (state_d[k] == S_ACTIVE) begin
            active_cnt_d = active_cnt_d + 3'd1;
         end
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge FrameClk or negedge ResetN) begin
      if (!ResetN) begin
         for (int k = 0; k < SLOTS; k++) begin
            state_q[k] <= S_IDLE;
         end
         age_q        <= '0;
         type_q       <= '0;
         spawn_en_q   <= '0;
         gap_q        <= MIN_GAP;
         lfsr_q       <= SEED;
         active_cnt_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         age_q        <= age_d;
         type_q       <= type_d;
         spawn_en_q   <= spawn_en_d;
         gap_q        <= gap_d;
         lfsr_q       <= lfsr_d;
         active_cnt_q <= active_cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lane_spawner.sv
// ============================================================================
// Module   : tb_lane_spawner
// Purpose  : Self-checking bench for lane_spawner with a behavioural model
//            that tracks remaining on-screen frames per slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lane_spawner;

   localparam int          SLOTS     = 3;
   localparam logic [10:0] LIFETIME  = 11'd12;
   localparam logic [7:0]  MIN_GAP   = 8'd3;
   localparam logic [5:0]  GAP_MASK  = 6'h03;
   localparam logic [7:0]  SEED      = 8'h01;

   logic               FrameClk = 1'b0;
   logic               ResetN   = 1'b0;
   logic               LaneEnable = 1'b1;
   logic [SLOTS-1:0]   SpawnEnable;
   logic [2*SLOTS-1:0] Type;
   logic [9:0]         SpawnX, SpawnY;
   logic               FaceLeft;
   logic [2:0]         Speed, ActiveCount;

   logic [3:0]         d_en;
   logic [7:0]         d_type;
   logic [9:0]         d_x, d_y;
   logic               d_face;
   logic [2:0]         d_speed, d_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   always #5 FrameClk = ~FrameClk;

   lane_spawner #(
      .SLOTS(SLOTS), .LANE_Y(10'd300), .FACE_LEFT(1'b1), .SPEED(3'd5),
      .LIFETIME(LIFETIME), .MIN_GAP(MIN_GAP), .GAP_MASK(GAP_MASK), .SEED(SEED)
   ) u_dut (
      .FrameClk(FrameClk), .ResetN(ResetN), .LaneEnable(LaneEnable),
      .SpawnEnable(SpawnEnable), .Type(Type), .SpawnX(SpawnX), .SpawnY(SpawnY),
      .FaceLeft(FaceLeft), .Speed(Speed), .ActiveCount(ActiveCount)
   );

   lane_spawner u_dflt (
      .FrameClk(FrameClk), .ResetN(ResetN), .LaneEnable(LaneEnable),
      .SpawnEnable(d_en), .Type(d_type), .SpawnX(d_x), .SpawnY(d_y),
      .FaceLeft(d_face), .Speed(d_speed), .ActiveCount(d_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_rem[k] = frames slot k will still show SpawnEnable high (0 = free).
   int         m_rem [SLOTS];
   logic [1:0] m_typ [SLOTS];
   int         m_gap;
   logic [7:0] m_lfsr;

   always @(posedge FrameClk or negedge ResetN) begin : model
      logic [7:0] pre;
      bit         free [SLOTS];
      bit         done;
      if (!ResetN) begin
         for (int k = 0; k < SLOTS; k++) begin m_rem[k] = 0; m_typ[k] = 2'd0; end
         m_gap  = MIN_GAP;
         m_lfsr = SEED;
      end else begin
         pre    = m_lfsr;
         m_lfsr = pre[0] ? ((pre >> 1) ^ 8'hB8) : (pre >> 1);
         if (!LaneEnable) begin
            for (int k = 0; k < SLOTS; k++) m_rem[k] = 0;
            m_gap = MIN_GAP;
         end else begin
            for (int k = 0; k < SLOTS; k++) begin
               free[k] = (m_rem[k] == 0);
               if (m_rem[k] > 0) m_rem[k] = m_rem[k] - 1;
            end
            if (m_gap > 0) begin
               m_gap = m_gap - 1;
            end else begin
               done = 0;
               for (int k = 0; k < SLOTS; k++) begin
                  if (!done && free[k]) begin
                     done     = 1;
                     m_rem[k] = LIFETIME;
                     m_typ[k] = pre[1:0];
                     m_gap    = MIN_GAP + ((pre >> 2) & GAP_MASK);
                     if (m_gap > 255) m_gap = 255;
                  end
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model on the inactive edge.
   always @(negedge FrameClk) begin
      logic [SLOTS-1:0]   e_en;
      logic [2*SLOTS-1:0] e_ty;
      int                 e_cnt;
      if (chk_on) begin
         e_cnt = 0;
         for (int k = 0; k < SLOTS; k++) begin
            e_en[k]        = (m_rem[k] > 0);
            e_ty[2*k +: 2] = m_typ[k];
            if (m_rem[k] > 0) e_cnt++;
         end
         check("model_SpawnEnable", SpawnEnable, e_en);
         check("model_Type", Type, e_ty);
         check("model_ActiveCount", ActiveCount, e_cnt);
      end
   end

   initial begin
      int r;
      // Reset state and lane constants.
      repeat (2) @(negedge FrameClk);
      check("rst_SpawnEnable", SpawnEnable, 0);
      check("rst_Type", Type, 0);
      check("rst_ActiveCount", ActiveCount, 0);
      check("SpawnX_left", SpawnX, 740);
      check("SpawnY", SpawnY, 300);
      check("FaceLeft", FaceLeft, 1);
      check("Speed", Speed, 5);
      check("SpawnX_right", d_x, 51);
      check("dflt_SpawnY", d_y, 200);
      check("dflt_Speed", d_speed, 2);
      check("dflt_rst_en", d_en, 0);
      ResetN = 1'b1;
      chk_on = 1'b1;

      // Hand-derived sequence from SEED=01 (pre-advance LFSR per edge:
      // e4=2E, e11=19, e17=93, e21=30).
      for (int n = 1; n <= 21; n++) begin
         @(posedge FrameClk); #1;
         case (n)
            3:  check("lit_e3_none", SpawnEnable, 3'b000);
            4:  begin check("lit_e4_first", SpawnEnable, 3'b001);
                      check("lit_e4_type0", Type[1:0], 2'd2); end
            10: check("lit_e10", SpawnEnable, 3'b001);
            11: begin check("lit_e11_slot1", SpawnEnable, 3'b011);
                      check("lit_e11_type1", Type[3:2], 2'd1); end
            15: check("lit_e15_last", SpawnEnable, 3'b011);
            16: check("lit_e16_retire", SpawnEnable, 3'b010);
            17: begin check("lit_e17_reuse0", SpawnEnable, 3'b011);
                      check("lit_e17_type0", Type[1:0], 2'd3); end
            21: begin check("lit_e21_full", SpawnEnable, 3'b111);
                      check("lit_e21_cnt", ActiveCount, 3); end
            default: ;
         endcase
      end

      // Lane drop with all slots active, then re-enable.
      @(negedge FrameClk); LaneEnable = 1'b0;
      @(posedge FrameClk); #1;
      check("drop_en", SpawnEnable, 3'b000);
      check("drop_cnt", ActiveCount, 0);
      @(negedge FrameClk); LaneEnable = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(posedge FrameClk); #1;
         if (n == 3) check("reen_e3", SpawnEnable, 3'b000);
         if (n == 4) check("reen_e4_slot0", SpawnEnable, 3'b001);
      end

      // Randomised lane enable toggling and occasional async reset.
      for (int c = 0; c < 4000; c++) begin
         @(negedge FrameClk);
         r = $urandom_range(0, 199);
         if (LaneEnable) begin
            if (r < 4) LaneEnable = 1'b0;
         end else if (r < 80) begin
            LaneEnable = 1'b1;
         end
         if (r == 199) begin
            @(posedge FrameClk); #3;
            ResetN = 1'b0;
            #1;
            check("async_rst_en", SpawnEnable, 0);
            check("async_rst_type", Type, 0);
            check("async_rst_cnt", ActiveCount, 0);
            @(negedge FrameClk);
            ResetN = 1'b1;
         end
      end

      @(negedge FrameClk);
      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
